// File: rtl/risc_pkg.sv
// Shared RISC-V core types: register-file geometry and the writeback payload.
package risc_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/risc_wb_fifo.sv
// In-order FIFO of writeback entries. The head is read straight from the
// storage array, with no bypass, so an entry pushed into an empty FIFO
// appears at the head one cycle later.
module risc_wb_fifo
  import risc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr];
  end

  // Pointers wrap naturally modulo DEPTH; push and pop together hold count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/risc_writeback_unit.sv
// Register-file writeback: arbitrates the load and ALU results into a FIFO,
// retires one write per cycle and tracks pending destinations for decode.
module risc_writeback_unit
  import risc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rset_lg,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic                  rsv_en,
  input  logic [REG_ADDR_W-1:0] rsv_rd,
  output logic                  WE,
  output logic [REG_ADDR_W-1:0] addr3,
  output logic [XLEN-1:0]       WD,
  output logic [NREGS-1:0]      pend_vec,
  output logic                  full,
  output logic                  empty,
  output logic [XLEN-1:0]       wb_count
);

  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic             push;
  logic             pop;
  logic             ld_hs;
  logic             alu_hs;
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_next;

  risc_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rset_lg),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Load has priority; writes to x0 complete the handshake but are dropped.
  always_comb begin
    ld_ready   = !full;
    alu_ready  = !full && !ld_valid;
    ld_hs      = ld_valid && ld_ready;
    alu_hs     = alu_valid && alu_ready;
    push       = (ld_hs && (ld_rd != '0)) || (alu_hs && (alu_rd != '0));
    push_entry = ld_hs ? '{rd: ld_rd, data: ld_data} : '{rd: alu_rd, data: alu_data};
  end

  // The register file never stalls, so a non-empty head always retires.
  always_comb begin
    pop   = !empty;
    WE    = !empty;
    addr3 = empty ? '0 : head.rd;
    WD    = empty ? '0 : head.data;
  end

  // A reservation in the retire cycle outranks the clear.
  always_comb begin
    pend_next = pend_q;
    if (pop) pend_next[head.rd] = 1'b0;
    if (rsv_en && (rsv_rd != '0)) pend_next[rsv_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rset_lg) begin
    if (!rset_lg) begin
      pend_q   <= '0;
      wb_count <= '0;
    end else begin
      pend_q <= pend_next;
      if (pop) wb_count <= wb_count + XLEN'(1);
    end
  end

  assign pend_vec = pend_q;

endmodule

// File: tb/tb_risc_writeback_unit.sv
// Bench for risc_writeback_unit: directed scenarios plus random traffic
// checked against a queue-based model of the writeback behaviour.
module tb_risc_writeback_unit;
  import risc_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rset_lg;
  logic        alu_valid, alu_ready, ld_valid, ld_ready, rsv_en;
  logic [4:0]  alu_rd, ld_rd, rsv_rd, addr3;
  logic [31:0] alu_data, ld_data, WD, pend_vec, wb_count;
  logic        WE, full, empty;

  logic        f_push, f_pop, f_full, f_empty;
  wb_entry_t   f_din, f_head;

  int vectors;
  int miscompares;

  wb_entry_t   mq[$];
  logic [31:0] m_pend;
  logic [31:0] m_wbc;

  risc_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rset_lg(rset_lg),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rsv_en(rsv_en), .rsv_rd(rsv_rd),
    .WE(WE), .addr3(addr3), .WD(WD), .pend_vec(pend_vec),
    .full(full), .empty(empty), .wb_count(wb_count)
  );

  risc_wb_fifo #(.DEPTH(DEPTH)) u_fifo_chk (
    .clk(clk), .rst_n(rset_lg), .push(f_push), .din(f_din),
    .pop(f_pop), .head(f_head), .full(f_full), .empty(f_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic re, input logic [4:0] rrd);
    ld_valid = lv;  ld_rd = lrd;   ld_data = ldat;
    alu_valid = av; alu_rd = ard;  alu_data = adat;
    rsv_en = re;    rsv_rd = rrd;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // Every output compared against what the model says the state is now.
  task automatic check_all();
    int n;
    n = mq.size();
    chk("we", 32'(WE), 32'(n > 0));
    chk("addr3", 32'(addr3), (n > 0) ? 32'(mq[0].rd) : 32'd0);
    chk("wd", WD, (n > 0) ? mq[0].data : 32'd0);
    chk("pend_vec", pend_vec, m_pend);
    chk("wb_count", wb_count, m_wbc);
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("ld_ready", 32'(ld_ready), 32'(n < DEPTH));
    chk("alu_ready", 32'(alu_ready), 32'((n < DEPTH) && !ld_valid));
  endtask

  // One clock edge of the writeback rules: retire head, reserve, accept.
  task automatic model_edge();
    bit        room;
    wb_entry_t e;
    room = (mq.size() < DEPTH);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_pend[e.rd] = 1'b0;
      m_wbc = m_wbc + 32'd1;
    end
    if (rsv_en && rsv_rd != 5'd0) m_pend[rsv_rd] = 1'b1;
    if (ld_valid && room) begin
      if (ld_rd != 5'd0) mq.push_back('{rd: ld_rd, data: ld_data});
    end else if (alu_valid && room) begin
      if (alu_rd != 5'd0) mq.push_back('{rd: alu_rd, data: alu_data});
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    mq.delete();
    m_pend = 32'd0;
    m_wbc = 32'd0;
    f_push = 1'b0; f_pop = 1'b0; f_din = '0;
    idle();
    rset_lg = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_we", 32'(WE), 32'd0);
    rset_lg = 1'b1;

    // Single ALU write
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    tick();
    idle();
    chk("alu1_we", 32'(WE), 32'd1);
    chk("alu1_addr3", 32'(addr3), 32'd5);
    chk("alu1_wd", WD, 32'hDEADBEEF);
    tick();
    chk("alu1_we_off", 32'(WE), 32'd0);
    chk("alu1_count", wb_count, 32'd1);

    // Load beats ALU; ALU goes next cycle
    set_in(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0);
    #1;
    chk("sim_alu_ready", 32'(alu_ready), 32'd0);
    chk("sim_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    chk("sim_addr3_a", 32'(addr3), 32'd3);
    chk("sim_wd_a", WD, 32'h11);
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0);
    tick();
    idle();
    chk("sim_addr3_b", 32'(addr3), 32'd4);
    chk("sim_wd_b", WD, 32'h22);
    tick();
    chk("sim_count", wb_count, 32'd3);

    // Write to x0 is dropped
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
    #1;
    chk("x0_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    idle();
    chk("x0_we", 32'(WE), 32'd0);
    chk("x0_empty", 32'(empty), 32'd1);
    chk("x0_count", wb_count, 32'd3);

    // Scoreboard set/clear and set-wins
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    tick();
    chk("sb_set", 32'(pend_vec[7]), 32'd1);
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    tick();
    chk("sb_inflight", 32'(pend_vec[7]), 32'd1);
    chk("sb_addr3", 32'(addr3), 32'd7);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    tick();
    chk("sb_set_wins", 32'(pend_vec[7]), 32'd1);
    chk("sb_count", wb_count, 32'd4);
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0);
    tick();
    idle();
    tick();
    chk("sb_clear", 32'(pend_vec[7]), 32'd0);
    chk("sb_count2", wb_count, 32'd5);

    // Back-to-back writes across several pointer wraps
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 4; k++) begin
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 32'(k * 16 + r), 1'b0, 5'd0);
        tick();
        chk("wrap_addr3", 32'(addr3), 32'(k));
      end
    end
    idle();
    tick();
    chk("wrap_count", wb_count, 32'd17);

    // Asynchronous reset with work in flight
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd7);
    tick();
    chk("pre_rst_pend", pend_vec, 32'h000000E0);
    chk("pre_rst_we", 32'(WE), 32'd1);
    set_in(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #2;
    rset_lg = 1'b0;
    #1;
    chk("rst_we_async", 32'(WE), 32'd0);
    chk("rst_addr3", 32'(addr3), 32'd0);
    chk("rst_wd", WD, 32'd0);
    chk("rst_pend", pend_vec, 32'd0);
    chk("rst_empty_async", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wbc", wb_count, 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_alu_ready_lv", 32'(alu_ready), 32'd0);
    idle();
    #1;
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    rset_lg = 1'b1;
    mq.delete();
    m_pend = 32'd0;
    m_wbc = 32'd0;
    @(negedge clk);
    tick();
    chk("post_rst_we", 32'(WE), 32'd0);
    chk("post_rst_wbc", wb_count, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 3) == 0, 5'($urandom % 32), $urandom,
             ($urandom % 2) == 0, 5'($urandom % 32), $urandom,
             ($urandom % 10) < 3, 5'($urandom % 32));
      tick();
    end
    idle();
    tick();
    tick();

    // Standalone FIFO: fill to full, then drain in order
    for (int i = 0; i < 4; i++) begin
      f_push = 1'b1;
      f_din = '{rd: 5'(i + 1), data: 32'(i) * 32'h1111};
      @(posedge clk);
      @(negedge clk);
      if (i == 2) chk("fifo_not_full", 32'(f_full), 32'd0);
    end
    f_push = 1'b0;
    chk("fifo_full", 32'(f_full), 32'd1);
    chk("fifo_not_empty", 32'(f_empty), 32'd0);
    f_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fifo_head_rd", 32'(f_head.rd), 32'(i + 1));
      chk("fifo_head_data", f_head.data, 32'(i) * 32'h1111);
      @(posedge clk);
      @(negedge clk);
    end
    f_pop = 1'b0;
    chk("fifo_drained", 32'(f_empty), 32'd1);
    chk("fifo_drained_full", 32'(f_full), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
